// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register and its serial front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usr_pkg;

    // Width of the universal shift register; the receiver word width must match it.
    localparam int USR_W = 4;

    // Parity sense selectors for the receiver.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Receiver frame states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
// Latency: 2 clk cycles from input to output.
// Backpressure: none; the output simply follows the input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/shift_frame_rx.sv
// Serial frame receiver feeding the universal shift register's parallel-load port.
// Latency: word/error flags appear one cycle after the mid-bit stop sample (E+89 with defaults).
// Backpressure: one holding register; a good word arriving while it is full and not consumed is dropped with an overrun pulse.
module shift_frame_rx
    import usr_pkg::*;
#(
    parameter int   DATA_W       = USR_W,
    parameter int   CLKS_PER_BIT = 16,
    parameter int   PARITY_EN    = 0,
    parameter logic PARITY_ODD   = PAR_EVEN,
    parameter int   MSB_FIRST    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W + 1);

    // Half a bit minus one lands the start-bit sample mid-bit; full reloads step bit to bit.
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_W - 1);
    localparam logic          PAR_INV     = (PARITY_ODD == PAR_ODD);

    logic              rxd_s;
    rx_state_t         state;
    logic [CW-1:0]     bit_cnt;
    logic [IW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;
    logic              expiry;
    logic              good_word;

    // Shift one received bit into the word in the configured order.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
        if (MSB_FIRST != 0)
            shift_in = {cur[DATA_W-2:0], b};
        else
            shift_in = {b, cur[DATA_W-1:1]};
    endfunction

    // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign expiry    = (bit_cnt == '0);
    assign good_word = (state == STOP) && expiry && rxd_s && !par_bad;
    assign busy      = (state != IDLE);

    // Frame FSM: bit timing, shift-in, parity tracking and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state   <= START;
                        bit_cnt <= HALF_RELOAD;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                    end
                end
                START: begin
                    if (expiry) begin
                        // A start bit that is no longer low mid-bit was a glitch.
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_cnt <= BIT_RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (expiry) begin
                        shreg   <= shift_in(shreg, rxd_s);
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == LAST_IDX)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (expiry) begin
                        // Mismatch is held until the stop bit decides what to report.
                        par_bad <= rxd_s ^ (^shreg) ^ PAR_INV;
                        bit_cnt <= BIT_RELOAD;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (expiry) begin
                        if (rxd_s) begin
                            parity_err <= par_bad;
                            state      <= IDLE;
                        end else begin
                            // A framing error takes precedence over any parity mismatch.
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                BREAK: begin
                    if (rxd_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: load when empty or draining this cycle, otherwise drop and flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (good_word && (!dout_valid || dout_ready)) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
            end else begin
                if (dout_valid && dout_ready)
                    dout_valid <= 1'b0;
                if (good_word)
                    overrun <= 1'b1;
            end
        end
    end

endmodule
